// File: rtl/ifetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, issues one request at a time to
// instruction memory, buffers responses in order and flushes on redirect.
module ifetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            misalign,
  output logic [2:0]      dbg_state
);

  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_FULL = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fpc;
  logic            drop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] inst_mem [FIFO_DEPTH];

  logic        push;
  logic        pop;
  logic [AW:0] count_after;

  // Handshakes: imem_req is a one-cycle strobe with imem_addr; memory answers
  // with exactly one imem_rvalid cycle later. The head word moves downstream
  // on any edge where if_valid=1 and stall=0 (stall acts as !ready).
  always_comb begin
    push        = rst && !redirect && (state == S_WAIT) && imem_rvalid && !drop;
    pop         = if_valid && !stall;
    count_after = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = fpc;
  assign if_valid  = (count != '0);
  assign if_inst   = if_valid ? inst_mem[rd_ptr] : NOP;
  assign if_pc     = if_valid ? pc_mem[rd_ptr] : '0;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fpc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      fpc      <= RESET_PC;
      drop     <= 1'b0;
      misalign <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect && (state != S_HALT)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign <= 1'b1;
        state    <= S_HALT;
      end else begin
        fpc <= redirect_pc;
        case (state)
          // A request is already in flight; its answer belongs to the old path.
          S_REQ: begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end
          S_WAIT: begin
            if (imem_rvalid) begin
              state <= S_REQ;
              drop  <= 1'b0;
            end else begin
              drop <= 1'b1;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_after;
      case (state)
        S_IDLE: if (count < DEPTH_C) state <= S_REQ;
        S_REQ:  state <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              state <= (count_after < DEPTH_C) ? S_REQ : S_FULL;
            end
          end
        end
        S_FULL:  if (pop) state <= S_REQ;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: variable-latency memory model, expected-queue scoreboard,
// a redirect vector table and directed multi-cycle sequences.
module tb_ifetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [2:0]  ST_REQ   = 3'd1;
  localparam logic [2:0]  ST_FULL  = 3'd3;
  localparam logic [2:0]  ST_HALT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        misalign;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  ifetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  bit          m_halt;
  int          epoch;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          pend_tag;
  int          lat;
  int          req_count;
  int          pops;

  typedef struct {
    int          lat;
    int          delay;
    logic [31:0] rpc;
    logic        exp_mis;
    logic [31:0] exp_a0;
    logic [31:0] exp_a1;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: called at a falling edge with the inputs for the coming
  // rising edge already set; observes outputs, runs the memory, updates the model.
  task automatic step();
    bit          eff_redirect;
    bit          deliver;
    logic [31:0] del_addr;
    int          del_tag;
    int          old_epoch;
    deliver  = 1'b0;
    del_addr = '0;
    del_tag  = -1;
    if (rst === 1'b1) begin
      check("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (if_valid === 1'b1 && exp_q.size() != 0) begin
        check("if_pc", if_pc, exp_q[0][63:32]);
        check("if_inst", if_inst, exp_q[0][31:0]);
      end else if (if_valid === 1'b0) begin
        check("idle_inst", if_inst, NOP);
        check("idle_pc", if_pc, 32'h0);
      end
      check("misalign", 32'(misalign), 32'(m_halt));
      if (m_halt) check("halt_req", 32'(imem_req), 32'h0);
    end
    if (imem_req === 1'b1) begin
      req_count++;
      check("one_outstanding", 32'(pend), 32'h0);
      if (rst === 1'b1 && !m_halt) check("req_addr", imem_addr, exp_addr);
    end
    old_epoch    = epoch;
    eff_redirect = (rst === 1'b1) && redirect && !m_halt;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend        = 1'b0;
        deliver     = 1'b1;
        del_addr    = pend_addr;
        del_tag     = pend_tag;
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(pend_addr);
      end
    end
    if (imem_req === 1'b1) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = imem_addr;
      pend_tag  = old_epoch;
    end
    if (rst !== 1'b1) begin
      exp_q.delete();
      exp_addr = RESET_PC;
      m_halt   = 1'b0;
      epoch++;
    end else begin
      if (exp_q.size() != 0 && !stall && !eff_redirect) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (eff_redirect) begin
        exp_q.delete();
        epoch++;
        if (redirect_pc[1:0] != 2'b00) m_halt = 1'b1;
        else exp_addr = redirect_pc;
      end
      if (deliver && del_tag == epoch && !m_halt) begin
        exp_q.push_back({del_addr, data_of(del_addr)});
        exp_addr = del_addr + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles, input int new_lat);
    rst = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
    repeat (cycles) step();
    lat = new_lat;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_inst", if_inst, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b1;
    req_count = 0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_a);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin step(); n++; end
    check({name, "_seen"}, 32'(imem_req === 1'b1), 32'h1);
    if (imem_req === 1'b1) check(name, imem_addr, exp_a);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (if_valid !== 1'b1 && n < 40) begin step(); n++; end
    check({name, "_seen"}, 32'(if_valid === 1'b1), 32'h1);
    if (if_valid === 1'b1) begin
      check(name, if_pc, exp_pc);
      check({name, "_inst"}, if_inst, data_of(exp_pc));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p0;
    vecs[0] = '{1, 5, 32'h0000_0100, 1'b0, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{3, 2, 32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_0044};
    vecs[2] = '{2, 1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{1, 2, 32'h0000_0102, 1'b1, 32'h0, 32'h0};
    vecs[4] = '{2, 6, 32'h0000_0003, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{3, 0, 32'h0000_0080, 1'b0, 32'h0000_0080, 32'h0000_0084};
    vecs[6] = '{1, 2, 32'h0000_0020, 1'b0, 32'h0000_0020, 32'h0000_0024};

    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    exp_addr = RESET_PC; m_halt = 1'b0; epoch = 0; pend = 1'b0; pend_cnt = 0;
    pend_addr = '0; pend_tag = 0; lat = 1; req_count = 0; pops = 0;

    // Sequential fetch, latency 1, no stall.
    do_reset(5, 1);
    step();
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, RESET_PC);
    p0 = pops;
    repeat (40) step();
    check("t1_progress", 32'((pops - p0) >= 10), 32'h1);

    // Stall held, latency 3: buffer fills with 0 and 4, then drains in order.
    do_reset(5, 3);
    stall = 1'b1;
    repeat (20) step();
    check("t2_state", 32'(dbg_state), 32'(ST_FULL));
    check("t2_reqs", 32'(req_count), 32'd2);
    check("t2_head", if_pc, 32'h0);
    stall = 1'b0;
    step();
    check("t2_second", if_pc, 32'h4);
    check("t2_resume_req", 32'(imem_req), 32'h1);
    check("t2_resume_addr", imem_addr, 32'h8);

    // Redirect while the request for 0x8 waits.
    do_reset(5, 3);
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 60) begin step(); n++; end
    check("t3_req8_seen", 32'(imem_req === 1'b1 && imem_addr === 32'h8), 32'h1);
    step();
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    wait_req("t3_addr", 32'h100);
    wait_valid("t3_pc", 32'h100);

    // Redirect at the same edge as a response and a pop.
    do_reset(5, 2);
    stall = 1'b1;
    n = 0;
    while (!(pend && pend_cnt == 1 && exp_q.size() == 1) && n < 40) begin step(); n++; end
    check("t4_setup", 32'(pend && pend_cnt == 1 && exp_q.size() == 1), 32'h1);
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("t4_empty", 32'(if_valid), 32'h0);
    check("t4_state", 32'(dbg_state), 32'(ST_REQ));
    check("t4_req", 32'(imem_req), 32'h1);
    check("t4_addr", imem_addr, 32'h200);
    wait_valid("t4_pc", 32'h200);

    // Misaligned redirect halts until reset; aligned redirects are ignored there.
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    req_count = 0;
    check("t5_misalign", 32'(misalign), 32'h1);
    check("t5_valid", 32'(if_valid), 32'h0);
    check("t5_state", 32'(dbg_state), 32'(ST_HALT));
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    repeat (20) step();
    check("t5_noreq", 32'(req_count), 32'h0);
    check("t5_sticky", 32'(misalign), 32'h1);
    do_reset(1, 2);
    step();
    check("t5_restart_req", 32'(imem_req), 32'h1);
    check("t5_restart_addr", imem_addr, RESET_PC);

    // Redirect vector table.
    for (int i = 0; i < 7; i++) begin
      do_reset(5, vecs[i].lat);
      repeat (vecs[i].delay) step();
      redirect = 1'b1; redirect_pc = vecs[i].rpc;
      step();
      redirect = 1'b0;
      req_count = 0;
      if (vecs[i].exp_mis) begin
        repeat (15) step();
        check("vec_misalign", 32'(misalign), 32'h1);
        check("vec_noreq", 32'(req_count), 32'h0);
      end else begin
        wait_req("vec_a0", vecs[i].exp_a0);
        step();
        wait_req("vec_a1", vecs[i].exp_a1);
        check("vec_aligned", 32'(misalign), 32'h0);
      end
    end

    // Random stall/redirect soak with mid-run resets.
    for (int it = 0; it < 3; it++) begin
      do_reset(5, 1 + it);
      p0 = pops;
      for (int c = 0; c < 300; c++) begin
        stall       = ($urandom_range(0, 1) == 0);
        redirect    = ($urandom_range(0, 24) == 0);
        redirect_pc = 32'($urandom_range(0, 1023)) << 2;
        step();
      end
      redirect = 1'b0;
      check("soak_progress", 32'(pops > p0), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
